// File: rtl/pi_step_sequencer_pkg.sv
// Shared encodings and width helpers for the PI step sequencer.
package pi_step_sequencer_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_COMMIT = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    function automatic int ch_idx_width(input int num_ch);
        ch_idx_width = (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int wd_width(input int timeout);
        wd_width = $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/pi_step_sequencer_if.sv
// Step-timer / PI-bank signal bundle; slave is the sequencer, master the surrounding logic.
interface pi_step_sequencer_if
    import pi_step_sequencer_pkg::*;
#(
    parameter int NUM_CH = 4
);
    logic              step_start;
    logic [NUM_CH-1:0] ch_enable;
    logic [NUM_CH-1:0] ch_ready;
    logic [NUM_CH-1:0] done_sig_in;
    logic [NUM_CH-1:0] sta;
    logic              control_valuation_sig;
    logic              step_done;
    logic              busy;
    logic              timeout_err;
    logic              overrun_err;

    modport slave (
        input  step_start, ch_enable, ch_ready, done_sig_in,
        output sta, control_valuation_sig, step_done, busy, timeout_err, overrun_err
    );

    modport master (
        output step_start, ch_enable, ch_ready, done_sig_in,
        input  sta, control_valuation_sig, step_done, busy, timeout_err, overrun_err
    );
endinterface

// File: rtl/pi_step_sequencer_step_watchdog.sv
// Step watchdog: counts active cycles since clear and flags the cycle that reaches TIMEOUT.
module step_watchdog
    import pi_step_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int WD_W    = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] cnt_r;

    // Active-cycle counter, held once the limit is reached
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {WD_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {WD_W{1'b0}};
        end else if (enable && (cnt_r != LIMIT)) begin
            cnt_r <= cnt_r + WD_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = enable && (cnt_r == LIMIT);

endmodule

// File: rtl/pi_step_sequencer.sv
// Sequences one step over NUM_CH PI integrators: ordered sta issue, done collection,
// broadcast commit, then step completion.
module pi_step_sequencer
    import pi_step_sequencer_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int ISSUE_GAP = 0,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    pi_step_sequencer_if.slave   bus
);
    localparam int CH_IDX_W = ch_idx_width(NUM_CH);
    localparam int WD_W     = wd_width(TIMEOUT);
    localparam int GAP_W    = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;
    localparam logic [CH_IDX_W-1:0] LAST_IDX = CH_IDX_W'(NUM_CH - 1);
    localparam logic [GAP_W-1:0]    GAP_LOAD = GAP_W'(ISSUE_GAP);

    logic [2:0]          state_r, nxt_state_s;
    logic [CH_IDX_W-1:0] idx_r, nxt_idx_s;
    logic [GAP_W-1:0]    gap_r, nxt_gap_s;
    logic [NUM_CH-1:0]   en_r, nxt_en_s, pend_r, nxt_pend_s, done_r, nxt_done_s;
    logic [NUM_CH-1:0]   sta_r, nxt_sta_s;
    logic                commit_r, step_done_r, busy_r, timeout_r, overrun_r;
    logic                nxt_timeout_s, nxt_overrun_s, wd_clear_s, wd_run_s, wd_expire_s;

    // Issue evaluation: at acceptance channel 0 is judged against the fresh enable mask
    logic                accept_s, fire_s, advance_s;
    logic [NUM_CH-1:0]   eval_en_s, fire_mask_s, capture_s;
    logic [CH_IDX_W-1:0] eval_idx_s, adv_idx_s;

    assign accept_s    = (state_r == ST_IDLE) && bus.step_start;
    assign eval_en_s   = accept_s ? bus.ch_enable : en_r;
    assign eval_idx_s  = accept_s ? {CH_IDX_W{1'b0}} : idx_r;
    assign fire_s      = eval_en_s[eval_idx_s] && bus.ch_ready[eval_idx_s];
    assign advance_s   = !eval_en_s[eval_idx_s] || bus.ch_ready[eval_idx_s];
    assign fire_mask_s = fire_s ? (NUM_CH'(1'b1) << eval_idx_s) : {NUM_CH{1'b0}};
    assign adv_idx_s   = (eval_idx_s == LAST_IDX) ? {CH_IDX_W{1'b0}} : eval_idx_s + CH_IDX_W'(1);
    // A done in the same cycle as its own sta is not a real completion
    assign capture_s   = pend_r & ~sta_r & bus.done_sig_in;
    assign wd_run_s    = (state_r == ST_ISSUE) || (state_r == ST_WAIT);

    step_watchdog #(.TIMEOUT(TIMEOUT), .WD_W(WD_W)) u_wd (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear_s),
        .enable (wd_run_s),
        .expire (wd_expire_s)
    );

    // Next-state and next-output logic
    always_comb begin
        nxt_state_s   = state_r;
        nxt_idx_s     = idx_r;
        nxt_gap_s     = gap_r;
        nxt_en_s      = en_r;
        nxt_pend_s    = pend_r;
        nxt_done_s    = done_r;
        nxt_sta_s     = {NUM_CH{1'b0}};
        nxt_timeout_s = timeout_r;
        nxt_overrun_s = overrun_r | (bus.step_start && (state_r != ST_IDLE));
        wd_clear_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.step_start) begin
                    nxt_en_s      = bus.ch_enable;
                    nxt_done_s    = {NUM_CH{1'b0}};
                    nxt_timeout_s = 1'b0;
                    wd_clear_s    = 1'b1;
                    nxt_pend_s    = fire_mask_s;
                    nxt_sta_s     = fire_mask_s;
                    nxt_gap_s     = fire_s ? GAP_LOAD : {GAP_W{1'b0}};
                    nxt_idx_s     = advance_s ? adv_idx_s : eval_idx_s;
                    nxt_state_s   = (advance_s && (eval_idx_s == LAST_IDX)) ? ST_WAIT : ST_ISSUE;
                end else begin
                    nxt_state_s   = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                nxt_done_s = done_r | capture_s;
                if (wd_expire_s) begin
                    nxt_timeout_s = 1'b1;
                    nxt_state_s   = ST_DONE;
                end else if (gap_r != {GAP_W{1'b0}}) begin
                    nxt_gap_s     = gap_r - GAP_W'(1);
                end else begin
                    nxt_pend_s    = pend_r | fire_mask_s;
                    nxt_sta_s     = fire_mask_s;
                    nxt_gap_s     = fire_s ? GAP_LOAD : {GAP_W{1'b0}};
                    nxt_idx_s     = advance_s ? adv_idx_s : eval_idx_s;
                    nxt_state_s   = (advance_s && (eval_idx_s == LAST_IDX)) ? ST_WAIT : ST_ISSUE;
                end
            end
            ST_WAIT: begin
                nxt_done_s = done_r | capture_s;
                if (wd_expire_s) begin
                    nxt_timeout_s = 1'b1;
                    nxt_state_s   = ST_DONE;
                end else if (pend_r == {NUM_CH{1'b0}}) begin
                    nxt_state_s   = ST_DONE;
                end else if ((done_r | capture_s) == pend_r) begin
                    nxt_state_s   = ST_COMMIT;
                end else begin
                    nxt_state_s   = ST_WAIT;
                end
            end
            ST_COMMIT: nxt_state_s = ST_DONE;
            ST_DONE:   nxt_state_s = ST_IDLE;
            default:   nxt_state_s = ST_IDLE;
        endcase
    end

    // State, masks and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= {CH_IDX_W{1'b0}};
            gap_r       <= {GAP_W{1'b0}};
            en_r        <= {NUM_CH{1'b0}};
            pend_r      <= {NUM_CH{1'b0}};
            done_r      <= {NUM_CH{1'b0}};
            sta_r       <= {NUM_CH{1'b0}};
            commit_r    <= 1'b0;
            step_done_r <= 1'b0;
            busy_r      <= 1'b0;
            timeout_r   <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= nxt_state_s;
            idx_r       <= nxt_idx_s;
            gap_r       <= nxt_gap_s;
            en_r        <= nxt_en_s;
            pend_r      <= nxt_pend_s;
            done_r      <= nxt_done_s;
            sta_r       <= nxt_sta_s;
            commit_r    <= (nxt_state_s == ST_COMMIT);
            step_done_r <= (nxt_state_s == ST_DONE);
            busy_r      <= (nxt_state_s != ST_IDLE);
            timeout_r   <= nxt_timeout_s;
            overrun_r   <= nxt_overrun_s;
        end
    end

    assign bus.sta                   = sta_r;
    assign bus.control_valuation_sig = commit_r;
    assign bus.step_done             = step_done_r;
    assign bus.busy                  = busy_r;
    assign bus.timeout_err           = timeout_r;
    assign bus.overrun_err           = overrun_r;

endmodule

// File: tb/tb_pi_step_sequencer.sv
// Directed bench: two sequencers (ISSUE_GAP 0 and 2) with a done responder 20 cycles after sta.
module tb_pi_step_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;
    int   cyc;
    logic [3:0] h0 [0:255];
    logic [3:0] h2 [0:255];
    logic [3:0] resp_mask;
    logic [3:0] e_sta0, e_sta2;

    always #5 clk = ~clk;

    pi_step_sequencer_if #(.NUM_CH(4)) if0 ();
    pi_step_sequencer_if #(.NUM_CH(4)) if2 ();

    pi_step_sequencer #(.NUM_CH(4), .ISSUE_GAP(0), .TIMEOUT(64)) u_dut0 (
        .clk (clk), .rst (rst_n), .bus (if0.slave));
    pi_step_sequencer #(.NUM_CH(4), .ISSUE_GAP(2), .TIMEOUT(64)) u_dut2 (
        .clk (clk), .rst (rst_n), .bus (if2.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance one cycle, record sta and drive done 20 cycles after each sta
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        h0[cyc] = if0.sta;
        h2[cyc] = if2.sta;
        if (cyc >= 20) begin
            if0.done_sig_in = h0[cyc-20] & resp_mask;
            if2.done_sig_in = h2[cyc-20];
        end else begin
            if0.done_sig_in = 4'b0000;
            if2.done_sig_in = 4'b0000;
        end
    endtask

    task automatic new_test();
        for (int i = 0; i < 256; i++) begin
            h0[i] = 4'b0000;
            h2[i] = 4'b0000;
        end
        cyc = 0;
        if0.done_sig_in = 4'b0000;
        if2.done_sig_in = 4'b0000;
    endtask

    task automatic chk_idle0(input string tag);
        chk({tag, "_sta"},     32'(if0.sta), 32'd0);
        chk({tag, "_commit"},  32'(if0.control_valuation_sig), 32'd0);
        chk({tag, "_sdone"},   32'(if0.step_done), 32'd0);
        chk({tag, "_busy"},    32'(if0.busy), 32'd0);
        chk({tag, "_timeout"}, 32'(if0.timeout_err), 32'd0);
        chk({tag, "_overrun"}, 32'(if0.overrun_err), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        resp_mask = 4'b1111;
        if0.step_start = 1'b0; if0.ch_enable = 4'b0000; if0.ch_ready = 4'b0000;
        if2.step_start = 1'b0; if2.ch_enable = 4'b0000; if2.ch_ready = 4'b0000;
        new_test();
        repeat (3) @(posedge clk);
        #1;
        chk_idle0("rst0");
        chk("rst2_sta",  32'(if2.sta), 32'd0);
        chk("rst2_busy", 32'(if2.busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // T1 (gap 0) and T2 (gap 2): all enabled and ready
        if0.ch_enable = 4'b1111; if0.ch_ready = 4'b1111;
        if2.ch_enable = 4'b1111; if2.ch_ready = 4'b1111;
        new_test();
        if0.step_start = 1'b1; if2.step_start = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            tick();
            if0.step_start = 1'b0; if2.step_start = 1'b0;
            e_sta0 = (c <= 4) ? 4'(4'b0001 << (c - 1)) : 4'b0000;
            e_sta2 = (c <= 10 && ((c - 1) % 3) == 0) ? 4'(4'b0001 << ((c - 1) / 3)) : 4'b0000;
            chk("t1_sta",    32'(if0.sta), 32'(e_sta0));
            chk("t1_commit", 32'(if0.control_valuation_sig), 32'(c == 25));
            chk("t1_sdone",  32'(if0.step_done), 32'(c == 26));
            chk("t1_busy",   32'(if0.busy), 32'(c <= 26));
            chk("t2_sta",    32'(if2.sta), 32'(e_sta2));
            chk("t2_commit", 32'(if2.control_valuation_sig), 32'(c == 31));
            chk("t2_sdone",  32'(if2.step_done), 32'(c == 32));
            chk("t2_busy",   32'(if2.busy), 32'(c <= 32));
        end

        // T3: channels 0 and 2 enabled, channel 2 not ready until cycle 10
        if0.ch_enable = 4'b0101; if0.ch_ready = 4'b1011;
        new_test();
        if0.step_start = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            tick();
            if0.step_start = 1'b0;
            if (c == 9) if0.ch_ready = 4'b1111;
            e_sta0 = (c == 1) ? 4'b0001 : ((c == 10) ? 4'b0100 : 4'b0000);
            chk("t3_sta",    32'(if0.sta), 32'(e_sta0));
            chk("t3_commit", 32'(if0.control_valuation_sig), 32'(c == 31));
            chk("t3_sdone",  32'(if0.step_done), 32'(c == 32));
            chk("t3_busy",   32'(if0.busy), 32'(c <= 32));
        end

        // T4: nothing enabled
        if0.ch_enable = 4'b0000;
        new_test();
        if0.step_start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if0.step_start = 1'b0;
            chk("t4_sta",    32'(if0.sta), 32'd0);
            chk("t4_commit", 32'(if0.control_valuation_sig), 32'd0);
            chk("t4_sdone",  32'(if0.step_done), 32'(c == 5));
            chk("t4_busy",   32'(if0.busy), 32'(c <= 5));
        end

        // T5: done[3] withheld -> timeout at cycle 65, then a fresh step clears it
        if0.ch_enable = 4'b1111; if0.ch_ready = 4'b1111;
        resp_mask = 4'b0111;
        new_test();
        if0.step_start = 1'b1;
        for (int c = 1; c <= 66; c++) begin
            tick();
            if0.step_start = 1'b0;
            e_sta0 = (c <= 4) ? 4'(4'b0001 << (c - 1)) : 4'b0000;
            chk("t5_sta",     32'(if0.sta), 32'(e_sta0));
            chk("t5_commit",  32'(if0.control_valuation_sig), 32'd0);
            chk("t5_sdone",   32'(if0.step_done), 32'(c == 65));
            chk("t5_busy",    32'(if0.busy), 32'(c <= 65));
            chk("t5_timeout", 32'(if0.timeout_err), 32'(c >= 65));
        end
        resp_mask = 4'b1111;
        if0.step_start = 1'b1;
        for (int c = 67; c <= 93; c++) begin
            tick();
            if0.step_start = 1'b0;
            chk("t5b_timeout", 32'(if0.timeout_err), 32'd0);
            chk("t5b_commit",  32'(if0.control_valuation_sig), 32'(c == 91));
            chk("t5b_sdone",   32'(if0.step_done), 32'(c == 92));
            chk("t5b_overrun", 32'(if0.overrun_err), 32'd0);
        end

        // T6: repeated step_start while busy, then reset mid-step
        new_test();
        if0.step_start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if0.step_start = (c == 5);
            e_sta0 = (c <= 4) ? 4'(4'b0001 << (c - 1)) : 4'b0000;
            chk("t6_sta",     32'(if0.sta), 32'(e_sta0));
            chk("t6_busy",    32'(if0.busy), 32'd1);
            chk("t6_overrun", 32'(if0.overrun_err), 32'(c >= 6));
        end
        rst_n = 1'b0;
        #1;
        chk_idle0("t6_rst");
        repeat (3) tick();
        rst_n = 1'b1;
        while (cyc < 40) begin
            tick();
            chk("t6_post_sdone",  32'(if0.step_done), 32'd0);
            chk("t6_post_commit", 32'(if0.control_valuation_sig), 32'd0);
            chk("t6_post_busy",   32'(if0.busy), 32'd0);
            chk("t6_post_sta",    32'(if0.sta), 32'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
